// File: rtl/egress_meta_mailbox_pkg.sv
// Shared switch definitions: mailbox word layout and statistics widths.
package switch_pkg;

   localparam int unsigned META_PAYLOAD_W    = 31;
   localparam int unsigned MAILBOX_VALID_BIT = 31;
   localparam int unsigned DROP_CNT_W        = 16;

   typedef struct packed {
      logic                      valid;
      logic [META_PAYLOAD_W-1:0] payload;
   } mailbox_word_t;

endpackage

// File: rtl/egress_meta_mailbox_if.sv
// Egress push, software poll and status signals of the metadata mailbox.
interface egress_meta_mailbox_if
   import switch_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned PAYLOAD_W = META_PAYLOAD_W,
   parameter int unsigned DROP_W    = DROP_CNT_W
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                 meta_valid;
   logic [PAYLOAD_W-1:0] meta_data;
   logic                 clear;
   logic                 read_ack;
   logic [31:0]          mailbox_word;
   logic [CNT_W-1:0]     depth_count;
   logic                 overflow;
   logic [DROP_W-1:0]    drop_count;

   modport master (
      output meta_valid, meta_data, clear, read_ack,
      input  mailbox_word, depth_count, overflow, drop_count
   );

   modport slave (
      input  meta_valid, meta_data, clear, read_ack,
      output mailbox_word, depth_count, overflow, drop_count
   );

endinterface

// File: rtl/egress_meta_mailbox_sync_fifo.sv
// Register-based synchronous FIFO with occupancy counter and head lookahead.
module sync_fifo #(
   parameter int unsigned WIDTH = 31,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [WIDTH-1:0]           rdata_ahead_c,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rptr;
   logic [AW-1:0]    wptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == CW'(0));
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign rdata         = mem[rptr];
   assign rdata_ahead_c = mem[rptr + AW'(1)];
   assign count         = cnt;

   // Pointers wrap modulo DEPTH; the counter alone resolves full vs empty
   always_ff @(posedge clk) begin
      if (reset) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         if (do_push && !do_pop)      cnt <= cnt + CW'(1);
         else if (do_pop && !do_push) cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/egress_meta_mailbox.sv
// Metadata mailbox: buffers egress records and presents the head to software polling.
module egress_meta_mailbox
   import switch_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned PAYLOAD_W = META_PAYLOAD_W,
   parameter int unsigned DROP_W    = DROP_CNT_W
) (
   input logic                 clk,
   input logic                 reset,
   egress_meta_mailbox_if.slave mbx
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic                 flush;
   logic                 ack_q;
   logic                 presented_valid_q;
   mailbox_word_t        word_q;
   mailbox_word_t        word_d;
   logic                 overflow_q;
   logic [DROP_W-1:0]    drop_q;

   logic                 pop_c;
   logic                 push_c;
   logic                 drop_c;
   logic [PAYLOAD_W-1:0] head;
   logic [PAYLOAD_W-1:0] head_ahead;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CW-1:0]        fifo_count;

   assign flush  = reset | mbx.clear;
   assign pop_c  = mbx.read_ack & ~ack_q & presented_valid_q & ~fifo_empty;
   assign push_c = mbx.meta_valid & (~fifo_full | pop_c);
   assign drop_c = mbx.meta_valid & fifo_full & ~pop_c;

   sync_fifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset         (flush),
      .push          (push_c),
      .pop           (pop_c),
      .wdata         (mbx.meta_data),
      .rdata         (head),
      .rdata_ahead_c (head_ahead),
      .full          (fifo_full),
      .empty         (fifo_empty),
      .count         (fifo_count)
   );

   // Head as it will stand after this cycle's push/pop, so the word tracks the FIFO with one cycle latency
   always_comb begin
      word_d = '0;
      if (pop_c) begin
         if (fifo_count == CW'(1)) begin
            if (push_c) word_d = '{valid: 1'b1, payload: mbx.meta_data};
         end else begin
            word_d = '{valid: 1'b1, payload: head_ahead};
         end
      end else if (fifo_empty) begin
         if (push_c) word_d = '{valid: 1'b1, payload: mbx.meta_data};
      end else begin
         word_d = '{valid: 1'b1, payload: head};
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         ack_q             <= 1'b0;
         presented_valid_q <= 1'b0;
         word_q            <= '0;
         overflow_q        <= 1'b0;
         drop_q            <= '0;
      end else begin
         ack_q             <= mbx.read_ack;
         presented_valid_q <= word_q.valid;
         word_q            <= word_d;
         if (drop_c) begin
            overflow_q <= 1'b1;
            if (drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + DROP_W'(1);
         end
      end
   end

   assign mbx.mailbox_word = word_q;
   assign mbx.depth_count  = fifo_count;
   assign mbx.overflow     = overflow_q;
   assign mbx.drop_count   = drop_q;

endmodule

// File: doc/egress_meta_mailbox.md
Name: egress_meta_mailbox

Overview:
- Hardware-side responder for the software polling path: buffers metadata records produced by the egress datapath in a FIFO.
- Presents the head record as a single 32-bit word to the software register interface, which samples it on each poll read.
- Pops the head only when software acknowledges a read that returned a valid record, so no record is lost or duplicated.
- Counts and flags records dropped on overflow.

Parameters:
- DEPTH, 16, number of buffered records; power of two, minimum 2.
- PAYLOAD_W, 31, metadata payload width; the payload plus the valid flag must equal 32.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- meta_valid  input  1  egress pushes one record this cycle
- meta_data  input  PAYLOAD_W  egress record payload
- clear  input  1  synchronous flush from the control path; same effect as reset on all state
- read_ack  input  1  acknowledge level from the register interface; high for each cycle a poll read is in progress
- mailbox_word  output  32  to the register interface read data: {valid, payload}
- depth_count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: set when at least one record has been dropped
- drop_count  output  DROP_W  number of dropped records, saturating

Behaviour:
- Reset or clear:
  - FIFO empty; mailbox_word=0, depth_count=0, overflow=0, drop_count=0.
  - ack_q=0, presented_valid_q=0.
  - reset/clear takes priority over push and pop in the same cycle.
- Presentation:
  - mailbox_word is registered.
  - When non-empty: {1'b1, head payload}. When empty: 32'h0.
  - Updates one cycle after any push or pop.
  - Push into an empty FIFO is visible on mailbox_word at cycle N+1.
- presented_valid_q: registered copy of mailbox_word[31]. It records whether the word software sampled in the previous cycle was valid.
- Pop rule:
  - pop = read_ack & ~ack_q & presented_valid_q, where ack_q is read_ack delayed by one cycle.
  - The pop is edge-triggered, so a multi-cycle ack pops exactly once.
  - Ack while the sampled word was 0 never pops, even if a push in the meantime made the FIFO non-empty.
- Push rule:
  - push = meta_valid & (not full | pop).
  - Simultaneous push and pop while full is accepted and occupancy is unchanged.
  - Simultaneous push and pop with exactly one entry: the new record becomes head.
- Overflow:
  - meta_valid while full with no pop drops the record.
  - overflow is set and stays set until reset/clear.
  - drop_count increments and holds at all-ones.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter; no full/empty ambiguity.
- Ordering: records leave in strict arrival order.
- Reset mid-operation: in-flight ack edges are discarded. The first ack after reset cannot pop because presented_valid_q=0.
- Latency: push to visible is 1 cycle. The ack edge causes the next head (or 0) to appear 1 cycle after the pop cycle.

Decomposition:
- Shared package (switch_pkg) holds:
  - META_PAYLOAD_W=31
  - MAILBOX_VALID_BIT=31
  - a packed struct mailbox_word_t {logic valid; logic [30:0] payload}
  - the drop counter width constant
- One sub-module, sync_fifo:
  - parameterized width and depth.
  - Ports: push, pop, wdata, rdata (head), full, empty, count; registered storage.
- The top level adds the presentation register, ack edge detection, the pop gating and the drop statistics.

Test Plan:
1. Reset, then push payload 31'h0000_0ABC at cycle 5 → mailbox_word=32'h8000_0ABC at cycle 6, depth_count=1.
2. Push A=1, B=2, C=3. Hold read_ack for 3 cycles → exactly one pop. mailbox_word goes 32'h8000_0001 → 32'h8000_0002; depth_count goes 3 → 2.
3. FIFO empty, mailbox_word=0. read_ack rises in the same cycle as a push of 31'h5 → no pop. Next read sees 32'h8000_0005 and depth_count=1.
4. Fill 16 records, push 3 more with no ack → depth_count=16, overflow=1, drop_count=3. Records 0..15 are read back in order.
5. Full FIFO, push 31'h77 in the same cycle as an ack edge → depth_count stays 16, no drop; 31'h77 is read out last.
6. Assert clear while 5 records are queued and read_ack is high → next cycle mailbox_word=0, depth_count=0, overflow=0, drop_count=0. A subsequent ack edge pops nothing.
